instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameters SHALL be:
  OP_WIDTH, 4, opcode width presented to the control unit
  ADDR_WIDTH, 6, program-memory address width
  TIMEOUT, 16, maximum WAIT cycles allowed for an ALU op
REQ-002 Ports SHALL be:
  clk  in  1  single clock, rising edge
  rst_n  in  1  synchronous active-low reset
  start  in  1  begin program execution from start_addr (sampled in IDLE only)
  start_addr  in  ADDR_WIDTH  first program address
  abort  in  1  terminate the running program
  pmem_rd_en  out  1  program-memory read strobe
  pmem_addr  out  ADDR_WIDTH  program-memory address (= PC)
  pmem_rdata  in  OP_WIDTH  opcode, valid exactly 1 cycle after pmem_rd_en
  opcode_out  out  OP_WIDTH  opcode to control unit, registered
  op_valid  out  1  one-cycle issue strobe for opcode_out
  alu_done  in  1  ALU completion pulse
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle program-end pulse
  err  out  2  end status: 00 ok, 01 illegal opcode, 10 timeout, 11 abort

Function
REQ-003 FSM states SHALL be IDLE, FETCH, LATCH, EXEC, WAIT, DONE.
REQ-004 IDLE: start=1 -> PC<=start_addr, err<=00, next FETCH; start in any other state ignored.
REQ-005 FETCH: pmem_rd_en=1, pmem_addr=PC for one cycle; next LATCH; pmem_rd_en=0 in all other states.
REQ-006 LATCH: opcode register <= pmem_rdata; decode: 1110 (HALT) -> DONE, err=00, no issue; 1000-1101 -> DONE, err=01, no issue; all others -> EXEC.
REQ-007 EXEC: op_valid=1 for exactly this cycle with opcode_out = latched opcode; opcode_out holds its value until the next LATCH.
REQ-008 EXEC transition: opcodes 0000/0001/0010 (add/sub/mul) -> WAIT; 0011-0111 and 1111 (NOP) -> PC increment path (REQ-010).
REQ-009 WAIT: cycle counter cleared on entry, +1 per WAIT cycle; alu_done=1 -> PC increment path; counter reaching TIMEOUT-1 with alu_done=0 -> DONE, err=10; alu_done and timeout in same cycle -> alu_done wins.
REQ-010 PC increment path: if PC = 2^ADDR_WIDTH-1 -> DONE, err=00 (no wrap-around); else PC<=PC+1, next FETCH.
REQ-011 alu_done SHALL be ignored in every state except WAIT.
REQ-012 abort=1 in FETCH, LATCH, EXEC or WAIT SHALL force next state DONE with err=11; op_valid SHALL be 0 in that cycle (abort beats the EXEC issue); abort highest priority; ignored in IDLE and DONE.
REQ-013 DONE: done=1 for exactly one cycle, err valid and held until next start accepted; next IDLE.
REQ-014 Instruction latency: non-ALU op issues every 3 cycles (FETCH, LATCH, EXEC); ALU op takes 3 + WAIT cycles.

Reset
REQ-015 rst_n=0 at a rising edge SHALL, regardless of state, set state=IDLE, PC=0, opcode_out=1111, op_valid=0, pmem_rd_en=0, pmem_addr=0, busy=0, done=0, err=00, wait counter=0.
REQ-016 Reset mid-program SHALL discard the in-flight instruction with no op_valid or done pulse afterwards.

Verification
REQ-017 Program {0011,0101,1111,1110} at addr 0, start_addr=0 -> three op_valid pulses at cycles 3,6,9 after start with opcodes 0011,0101,1111; done at cycle 12 with err=00; PC final 3.
REQ-018 Program {0010,1110}, alu_done pulsed 4 cycles after mul issue -> one op_valid (0010), 4 WAIT cycles, then fetch addr 1, done with err=00.
REQ-019 Program {0000}, alu_done never asserted, TIMEOUT=16 -> DONE after 16 WAIT cycles, err=10, no further fetch.
REQ-020 Program {1001} -> no op_valid, done with err=01 two cycles after FETCH.
REQ-021 abort asserted in the EXEC cycle of the first op -> op_valid stays 0, done next cycle with err=11; start asserted during busy -> ignored.
REQ-022 start_addr=63, opcode 1111 at 63 -> NOP issued, done with err=00, PC does not wrap to 0; rst_n=0 during WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Program-memory and control-unit bus of the instruction sequencer.
// master = sequencer side, slave = memory / control-unit side.
interface instr_sequencer_if #(
  parameter int OP_WIDTH   = 4,
  parameter int ADDR_WIDTH = 6
);
  logic                  pmem_rd_en;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [OP_WIDTH-1:0]   pmem_rdata;
  logic [OP_WIDTH-1:0]   opcode_out;
  logic                  op_valid;
  logic                  alu_done;

  modport master (
    output pmem_rd_en, pmem_addr, opcode_out, op_valid,
    input  pmem_rdata, alu_done
  );

  modport slave (
    input  pmem_rd_en, pmem_addr, opcode_out, op_valid,
    output pmem_rdata, alu_done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches opcodes from program memory, issues them to
// the control unit, waits on ALU ops and reports the program's end status.
module instr_sequencer #(
  parameter int OP_WIDTH   = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err,
  instr_sequencer_if.master     bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [OP_WIDTH-1:0]   OP_ALU_HI = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0]   OP_ILL_LO = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0]   OP_ILL_HI = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0]   OP_HALT   = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0]   OP_NOP    = OP_WIDTH'(15);
  localparam logic [ADDR_WIDTH-1:0] PC_MAX    = '1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic                  op_valid;
  logic                  advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      opcode_q <= OP_NOP;
      cnt_q    <= '0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    op_valid = 1'b0;
    advance  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          err_d   = ERR_OK;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        opcode_d = bus.pmem_rdata;
        if (bus.pmem_rdata == OP_HALT) begin
          err_d   = ERR_OK;
          state_d = S_DONE;
        end else if (bus.pmem_rdata >= OP_ILL_LO && bus.pmem_rdata <= OP_ILL_HI) begin
          err_d   = ERR_ILLEGAL;
          state_d = S_DONE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        op_valid = 1'b1;
        if (opcode_q <= OP_ALU_HI) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completion arriving on the last allowed cycle still counts as success.
        if (bus.alu_done) begin
          advance = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The program ends at the top of memory instead of wrapping to address 0.
    if (advance) begin
      if (pc_q == PC_MAX) begin
        err_d   = ERR_OK;
        state_d = S_DONE;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      op_valid = 1'b0;
      pc_d     = pc_q;
      err_d    = ERR_ABORT;
      state_d  = S_DONE;
    end
  end

  assign bus.pmem_rd_en = (state_q == S_FETCH);
  assign bus.pmem_addr  = pc_q;
  assign bus.opcode_out = opcode_q;
  assign bus.op_valid   = op_valid;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, hand-written corner
// sequences and randomized programs checked against a cycle-timeline model.
module tb_instr_sequencer;

  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] start_addr = '0;
  logic       abort = 1'b0;
  logic       busy, done;
  logic [1:0] err;

  instr_sequencer_if sif ();

  instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bus        (sif.master)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [64];
  always @(posedge clk) begin
    if (sif.pmem_rd_en) sif.pmem_rdata <= mem[sif.pmem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus schedules, indexed by cycle number after start is sampled
  bit alu_s [MAXC];
  bit abort_s [MAXC];
  bit start_s [MAXC];

  // observed per-cycle DUT outputs
  logic       o_valid [MAXC];
  logic [3:0] o_op    [MAXC];
  logic       o_rd    [MAXC];
  logic [5:0] o_addr  [MAXC];
  logic       o_busy  [MAXC];
  logic       o_done  [MAXC];
  logic [1:0] o_err   [MAXC];
  int         obs_done;

  // reference timeline
  bit         e_valid [MAXC];
  logic [3:0] e_op    [MAXC];
  bit         e_rd    [MAXC];
  logic [5:0] e_pc    [MAXC];
  bit         in_wait [MAXC];
  int         e_dc;
  logic [1:0] e_err;

  typedef struct {
    logic [15:0] prog;
    int          plen;
    logic [5:0]  saddr;
    int          alu_cyc;
    int          abort_cyc;
    int          start_cyc;
    bit          spur;
    int          x_done;
    logic [1:0]  x_err;
    logic [5:0]  x_pc;
    logic [31:0] x_vmask;
    logic [15:0] x_ops;
    logic [31:0] x_fmask;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " busy"},       32'(busy), 0);
    chk({tag, " done"},       32'(done), 0);
    chk({tag, " op_valid"},   32'(sif.op_valid), 0);
    chk({tag, " pmem_rd_en"}, 32'(sif.pmem_rd_en), 0);
    chk({tag, " pmem_addr"},  32'(sif.pmem_addr), 0);
    chk({tag, " opcode_out"}, 32'(sif.opcode_out), 32'hF);
    chk({tag, " err"},        32'(err), 0);
  endtask

  task automatic clear_sched();
    foreach (alu_s[i]) begin
      alu_s[i] = 0; abort_s[i] = 0; start_s[i] = 0;
    end
  endtask

  task automatic fill_mem_halt();
    foreach (mem[i]) mem[i] = 4'hE;
  endtask

  // Start a program and record outputs until one cycle past done.
  task automatic run_case(input logic [5:0] saddr, input int max_cyc, input string tag);
    foreach (o_valid[i]) begin
      o_valid[i] = 0; o_op[i] = 0; o_rd[i] = 0; o_addr[i] = 0;
      o_busy[i] = 0; o_done[i] = 0; o_err[i] = 0;
    end
    obs_done = -1;
    @(negedge clk);
    start = 1'b1;
    start_addr = saddr;
    for (int k = 1; k <= max_cyc && k < MAXC; k++) begin
      @(negedge clk);
      start = start_s[k];
      if (start_s[k]) start_addr = 6'($urandom);
      abort = abort_s[k];
      sif.alu_done = alu_s[k];
      #1;
      o_valid[k] = sif.op_valid;
      o_op[k]    = sif.opcode_out;
      o_rd[k]    = sif.pmem_rd_en;
      o_addr[k]  = sif.pmem_addr;
      o_busy[k]  = busy;
      o_done[k]  = done;
      o_err[k]   = err;
      if (done === 1'b1 && obs_done < 0) obs_done = k;
      if (obs_done >= 0 && k == obs_done + 1) break;
    end
    start = 1'b0;
    abort = 1'b0;
    sif.alu_done = 1'b0;
    chk({tag, " finished in budget"}, 32'(obs_done >= 0), 1);
    if (obs_done < 0) do_reset();
  endtask

  // Timeline model: walks the program from the opcode rules and timing
  // (3 cycles per instruction plus ALU wait cycles), then overlays abort.
  task automatic build_model(input logic [5:0] saddr);
    int t, e, d, dc, a;
    logic [5:0] pc;
    logic [3:0] op;
    bit term;
    logic [1:0] er;
    foreach (e_valid[i]) begin
      e_valid[i] = 0; e_op[i] = 0; e_rd[i] = 0; e_pc[i] = 0; in_wait[i] = 0;
    end
    clear_sched();
    pc = saddr; t = 1; term = 0; dc = 0; er = 0;
    while (!term) begin
      e_rd[t] = 1; e_pc[t] = pc; e_pc[t+1] = pc;
      op = mem[pc];
      if (op == 4'hE || (op >= 4'd8 && op <= 4'd13)) begin
        dc = t + 2; er = (op == 4'hE) ? 2'd0 : 2'd1; term = 1;
      end else begin
        e = t + 2; e_pc[e] = pc; e_valid[e] = 1; e_op[e] = op; t = e + 1;
        if (op <= 4'd2) begin
          d = $urandom_range(1, 20);
          if (d <= 16) begin
            alu_s[e+d] = 1;
            for (int c = e + 1; c <= e + d; c++) begin in_wait[c] = 1; e_pc[c] = pc; end
            t = e + d + 1;
          end else begin
            for (int c = e + 1; c <= e + 16; c++) begin in_wait[c] = 1; e_pc[c] = pc; end
            dc = e + 17; er = 2; term = 1;
          end
        end
        if (!term) begin
          if (pc == 6'd63) begin dc = t; er = 0; term = 1; end
          else pc = pc + 1;
        end
      end
    end
    e_pc[dc] = pc;
    if ($urandom_range(0, 3) == 0) begin
      a = $urandom_range(1, dc - 1);
      abort_s[a] = 1;
      e_valid[a] = 0;
      for (int k = a + 1; k <= dc; k++) begin e_valid[k] = 0; e_rd[k] = 0; end
      dc = a + 1; er = 3; e_pc[dc] = e_pc[a];
    end
    for (int k = 1; k <= dc; k++) begin
      if (!in_wait[k] && $urandom_range(0, 3) == 0) alu_s[k] = 1;
      start_s[k] = ($urandom_range(0, 7) == 0);
    end
    e_dc = dc;
    e_err = er;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vmask, fmask;
    logic [15:0] ops;
    int nv, nd;
    string tag;

    //                prog      len sa  alu ab  st sp  done err pc  vmask  ops    fmask
    tbl[0]  = '{16'hEF53, 4, 6'd0,  0,  0,  0, 0, 12, 2'd0, 6'd3,  32'h248, 16'hF53, 32'h492};
    tbl[1]  = '{16'h00E2, 2, 6'd0,  7,  0,  0, 0, 10, 2'd0, 6'd1,  32'h8,   16'h2,   32'h102};
    tbl[2]  = '{16'h0000, 1, 6'd0,  0,  0,  0, 1, 20, 2'd2, 6'd0,  32'h8,   16'h0,   32'h2};
    tbl[3]  = '{16'h0009, 1, 6'd0,  0,  0,  0, 0, 3,  2'd1, 6'd0,  32'h0,   16'h0,   32'h2};
    tbl[4]  = '{16'h00E3, 2, 6'd0,  0,  3,  2, 0, 4,  2'd3, 6'd0,  32'h0,   16'h0,   32'h2};
    tbl[5]  = '{16'h000F, 1, 6'd63, 0,  0,  0, 0, 4,  2'd0, 6'd63, 32'h8,   16'hF,   32'h2};
    tbl[6]  = '{16'h00E0, 2, 6'd0,  19, 0,  0, 0, 22, 2'd0, 6'd1,  32'h8,   16'h0,   32'h100002};
    tbl[7]  = '{16'h0EF3, 3, 6'd0,  0,  4,  0, 0, 5,  2'd3, 6'd1,  32'h8,   16'h3,   32'h12};
    tbl[8]  = '{16'h00E1, 2, 6'd0,  0,  6,  0, 0, 7,  2'd3, 6'd0,  32'h8,   16'h1,   32'h2};
    tbl[9]  = '{16'h000D, 1, 6'd10, 0,  0,  3, 0, 3,  2'd1, 6'd10, 32'h0,   16'h0,   32'h2};
    tbl[10] = '{16'h0087, 2, 6'd5,  0,  0,  0, 0, 6,  2'd1, 6'd6,  32'h8,   16'h7,   32'h12};

    sif.alu_done = 1'b0;
    sif.pmem_rdata = '0;
    fill_mem_halt();
    start = 1'b1;
    abort = 1'b1;
    sif.alu_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_values("reset");
    start = 1'b0; abort = 1'b0; sif.alu_done = 1'b0;
    rst_n = 1'b1;

    // directed vector table
    for (int r = 0; r < 11; r++) begin
      tag = $sformatf("vec%0d", r);
      fill_mem_halt();
      for (int i = 0; i < tbl[r].plen; i++) mem[6'(tbl[r].saddr + 6'(i))] = tbl[r].prog[4*i +: 4];
      clear_sched();
      if (tbl[r].alu_cyc > 0)   alu_s[tbl[r].alu_cyc] = 1;
      if (tbl[r].abort_cyc > 0) abort_s[tbl[r].abort_cyc] = 1;
      if (tbl[r].start_cyc > 0) start_s[tbl[r].start_cyc] = 1;
      if (tbl[r].spur) begin alu_s[1] = 1; alu_s[2] = 1; alu_s[3] = 1; end
      run_case(tbl[r].saddr, 40, tag);
      vmask = '0; fmask = '0; ops = '0; nv = 0;
      for (int k = 1; k < 32; k++) begin
        if (o_valid[k] === 1'b1) begin
          vmask[k] = 1'b1;
          if (nv < 4) ops[4*nv +: 4] = o_op[k];
          nv++;
        end
        if (o_rd[k] === 1'b1) fmask[k] = 1'b1;
      end
      chk({tag, " done cycle"}, 32'(obs_done), 32'(tbl[r].x_done));
      if (obs_done > 0) begin
        chk({tag, " err"}, 32'(o_err[obs_done]), 32'(tbl[r].x_err));
        chk({tag, " final pc"}, 32'(o_addr[obs_done]), 32'(tbl[r].x_pc));
        chk({tag, " idle after done"}, 32'(o_busy[obs_done + 1]), 0);
      end
      chk({tag, " issue cycles"}, vmask, tbl[r].x_vmask);
      chk({tag, " issued opcodes"}, 32'(ops), 32'(tbl[r].x_ops));
      chk({tag, " fetch cycles"}, fmask, tbl[r].x_fmask);
      $display("vector %0d: done@%0d err=%0d pc=%0d issues=%0d", r, obs_done,
               (obs_done > 0) ? o_err[obs_done] : 2'd0, (obs_done > 0) ? o_addr[obs_done] : 6'd0, nv);
    end

    // err held through idle until the next accepted start
    fill_mem_halt();
    mem[20] = 4'h9;
    clear_sched();
    run_case(6'd20, 10, "hold");
    repeat (3) @(negedge clk);
    chk("hold err in idle", 32'(err), 1);
    start = 1'b1; start_addr = 6'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("hold err cleared on start", 32'(err), 0);
    chk("hold busy after start", 32'(busy), 1);
    nd = 0;
    for (int k = 0; k < 10 && nd == 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin nd = 1; chk("hold halt err", 32'(err), 0); end
    end
    chk("hold halt finished", 32'(nd), 1);
    $display("sequence err-hold: checked");

    // reset while waiting on the ALU
    fill_mem_halt();
    mem[0] = 4'h0;
    @(negedge clk);
    start = 1'b1; start_addr = 6'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_values("wait-reset");
    rst_n = 1'b1;
    nv = 0; nd = 0;
    sif.alu_done = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (sif.op_valid === 1'b1) nv++;
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    sif.alu_done = 1'b0;
    chk("wait-reset no issue after", 32'(nv), 0);
    chk("wait-reset no done after", 32'(nd), 0);
    $display("sequence reset-in-wait: checked");

    // randomized programs against the timeline model
    for (int r = 0; r < 30; r++) begin
      logic [5:0] sa;
      tag = $sformatf("rnd%0d", r);
      for (int i = 0; i < 64; i++) begin
        int c;
        c = $urandom_range(0, 99);
        if (c < 35)      mem[i] = 4'($urandom_range(0, 2));
        else if (c < 70) mem[i] = 4'($urandom_range(3, 7));
        else if (c < 77) mem[i] = 4'hF;
        else if (c < 89) mem[i] = 4'hE;
        else             mem[i] = 4'($urandom_range(8, 13));
      end
      sa = (r % 4 == 0) ? 6'($urandom_range(58, 63)) : 6'($urandom);
      build_model(sa);
      run_case(sa, e_dc + 1, tag);
      for (int k = 1; k <= e_dc + 1; k++) begin
        chk($sformatf("%s op_valid@%0d", tag, k), 32'(o_valid[k]), 32'(e_valid[k]));
        if (e_valid[k]) chk($sformatf("%s opcode@%0d", tag, k), 32'(o_op[k]), 32'(e_op[k]));
        chk($sformatf("%s rd_en@%0d", tag, k), 32'(o_rd[k]), 32'(e_rd[k]));
        chk($sformatf("%s busy@%0d", tag, k), 32'(o_busy[k]), 32'(k <= e_dc));
        chk($sformatf("%s done@%0d", tag, k), 32'(o_done[k]), 32'(k == e_dc));
        if (k <= e_dc) chk($sformatf("%s pc@%0d", tag, k), 32'(o_addr[k]), 32'(e_pc[k]));
        chk($sformatf("%s err@%0d", tag, k), 32'(o_err[k]), (k < e_dc) ? 32'd0 : 32'(e_err));
      end
      $display("random %0d: start=%0d expected done@%0d err=%0d observed done@%0d", r, sa, e_dc, e_err, obs_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
